// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants used by master and target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRegPtr,
    StPtrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for SCL/SDA plus edge and START/STOP detection on the synced lines.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // Idle bus is high, so reset the chain to 1 to avoid spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file: pointer write, auto-incrementing reads and bus writes.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h29,
  parameter int unsigned REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              loc_we,
  input  logic [REG_AW-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              bus_wr_stb,
  output logic [REG_AW-1:0] bus_wr_adr,
  output logic [7:0]        bus_wr_dat,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** REG_AW;

  logic              scl_rise, scl_fall, start_det, stop_det, sda_s;
  i2c_state_e        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [REG_AW-1:0] ptr;
  logic              ack_phase;
  logic              rw;
  logic [7:0]        regs [Depth];
  logic [7:0]        rx_byte;
  logic [7:0]        rd_byte;
  logic              bus_we;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign rx_byte = {shreg[6:0], sda_s};
  assign rd_byte = regs[ptr];
  assign bus_we  = (state == StWrData) && scl_rise && (bit_cnt == 3'd7);

  // Bus write wins over a local write to the same address in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) regs[i] <= '0;
    end else begin
      if (loc_we && !(bus_we && (loc_addr == ptr))) regs[loc_addr] <= loc_wdata;
      if (bus_we) regs[ptr] <= rx_byte;
    end
  end

  // ack_phase marks that the 9th SCL rise has been seen, so the next fall ends the ACK slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      ack_phase  <= 1'b0;
      rw         <= I2C_RW_WRITE;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      bus_wr_stb <= 1'b0;
      bus_wr_adr <= '0;
      bus_wr_dat <= '0;
    end else begin
      bus_wr_stb <= 1'b0;
      if (stop_det) begin
        state     <= StIdle;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= StAddr;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StIgnore: ;
          StAddr: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state <= StAddrAck;
                busy  <= 1'b1;
                rw    <= rx_byte[0];
              end else begin
                state <= StIgnore;
                busy  <= 1'b0;
              end
            end
          end
          StAddrAck, StPtrAck, StWrAck: begin
            if (scl_rise) ack_phase <= 1'b1;
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == StAddrAck && rw == I2C_RW_READ) begin
                  shreg  <= rd_byte;
                  sda_oe <= ~rd_byte[7];
                  ptr    <= ptr + 1'b1;
                  state  <= StRdData;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == StAddrAck) ? StRegPtr : StWrData;
                end
              end
            end
          end
          StRegPtr: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[REG_AW-1:0];
              state <= StPtrAck;
            end
          end
          StWrData: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus_wr_stb <= 1'b1;
              bus_wr_adr <= ptr;
              bus_wr_dat <= rx_byte;
              ptr        <= ptr + 1'b1;
              state      <= StWrAck;
            end
          end
          StRdData: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= StRdAck;
            end
            if (scl_fall) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                state <= StIgnore;
                busy  <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe <= 1'b0;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                shreg     <= rd_byte;
                sda_oe    <= ~rd_byte[7];
                ptr       <= ptr + 1'b1;
                state     <= StRdData;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master with read-data and write-strobe scoreboards.
module tb_i2c_target_regfile;

  localparam int T = 10;  // clk cycles per SCL half period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       sda_line;
  logic       loc_we = 1'b0;
  logic [4:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       bus_wr_stb;
  logic [4:0] bus_wr_adr;
  logic [7:0] bus_wr_dat;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  rd_q[$];
  logic [12:0] stb_q[$];
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'h29), .REG_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .loc_we     (loc_we),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .bus_wr_stb (bus_wr_stb),
    .bus_wr_adr (bus_wr_adr),
    .bus_wr_dat (bus_wr_dat),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!rst && bus_wr_stb) begin
      if (stb_q.size() == 0) begin
        check("stb_unexpected", 32'd1, 32'd0);
      end else begin
        logic [12:0] e;
        e = stb_q.pop_front();
        check("stb_adr", {27'd0, bus_wr_adr}, {27'd0, e[12:8]});
        check("stb_dat", {24'd0, bus_wr_dat}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (T) @(negedge clk);
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; half();
    scl_m = 1'b1; half();
    sda_m = 1'b0; half();
    scl_m = 1'b0; gap();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half();
    scl_m = 1'b1; half();
    sda_m = 1'b1; half();
  endtask

  // coll: pulse loc_we in the exact cycle the target commits the 8th data bit.
  task automatic write_byte(input logic [7:0] b, input logic coll, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; half();
      scl_m = 1'b1;
      if (coll && i == 0) begin
        @(posedge clk); @(posedge clk);
        @(negedge clk) loc_we = 1'b1;
        @(negedge clk) loc_we = 1'b0;
        repeat (T - 2) @(negedge clk);
      end else begin
        half();
      end
      scl_m = 1'b0; gap();
    end
    sda_m = 1'b1; half();
    scl_m = 1'b1;
    repeat (T / 2) @(negedge clk);
    ack = sda_line;
    repeat (T / 2) @(negedge clk);
    scl_m = 1'b0; gap();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      half();
      scl_m = 1'b1;
      repeat (T / 2) @(negedge clk);
      b[i] = sda_line;
      repeat (T / 2) @(negedge clk);
      scl_m = 1'b0;
    end
    gap();
    sda_m = nack; half();
    scl_m = 1'b1; half();
    scl_m = 1'b0; gap();
    sda_m = 1'b1;
  endtask

  task automatic wr(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    write_byte(b, 1'b0, ack);
    check(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic rd(input string tag, input logic nack);
    logic [7:0] b;
    logic [7:0] e;
    read_byte(nack, b);
    if (rd_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = rd_q.pop_front();
      check(tag, {24'd0, b}, {24'd0, e});
    end
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  initial begin
    logic ack;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb", {31'd0, bus_wr_stb}, 32'd0);
    check("rst_adr", {27'd0, bus_wr_adr}, 32'd0);
    check("rst_dat", {24'd0, bus_wr_dat}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write pointer, repeated START, read two bytes.
    loc_write(5'h14, 8'hAB);
    loc_write(5'h15, 8'hCD);
    i2c_start();
    wr("wpr_addr_ack", 8'h52, 1'b0);
    check("wpr_busy", {31'd0, busy}, 32'd1);
    wr("wpr_ptr_ack", 8'h14, 1'b0);
    i2c_start();
    wr("wpr_raddr_ack", 8'h53, 1'b0);
    rd_q.push_back(8'hAB);
    rd_q.push_back(8'hCD);
    rd("wpr_rd0", 1'b0);
    rd("wpr_rd1", 1'b1);
    i2c_stop();
    check("wpr_busy_end", {31'd0, busy}, 32'd0);

    // Address miss: no drive, no busy, no strobe.
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    wr("miss_ack", 8'h54, 1'b1);
    wr("miss_data_ack", 8'h52, 1'b1);
    i2c_stop();
    check("miss_oe", {31'd0, oe_seen}, 32'd0);
    check("miss_busy", {31'd0, busy_seen}, 32'd0);

    // Bus write across the pointer wrap, then read back.
    i2c_start();
    wr("wrap_addr_ack", 8'h52, 1'b0);
    wr("wrap_ptr_ack", 8'h1F, 1'b0);
    stb_q.push_back({5'h1F, 8'h11});
    stb_q.push_back({5'h00, 8'h22});
    wr("wrap_d0_ack", 8'h11, 1'b0);
    wr("wrap_d1_ack", 8'h22, 1'b0);
    i2c_stop();
    check("wrap_stb_drained", stb_q.size(), 32'd0);
    i2c_start();
    wr("wrb_addr_ack", 8'h52, 1'b0);
    wr("wrb_ptr_ack", 8'hFF, 1'b0);  // upper pointer bits ignored -> 0x1F
    i2c_start();
    wr("wrb_raddr_ack", 8'h53, 1'b0);
    rd_q.push_back(8'h11);
    rd_q.push_back(8'h22);
    rd("wrb_rd0", 1'b0);
    rd("wrb_rd1", 1'b1);
    i2c_stop();

    // Read with NACK continues from the persistent pointer (0x01), then bus ignored until STOP.
    i2c_start();
    wr("nack_addr_ack", 8'h53, 1'b0);
    rd_q.push_back(8'h00);
    rd("nack_rd", 1'b1);
    check("nack_busy", {31'd0, busy}, 32'd0);
    oe_seen = 1'b0;
    wr("nack_ign_ack", 8'h00, 1'b1);
    check("nack_oe", {31'd0, oe_seen}, 32'd0);
    i2c_stop();

    // Local and bus write collide on address 0x05: bus value must stick.
    i2c_start();
    wr("coll_addr_ack", 8'h52, 1'b0);
    wr("coll_ptr_ack", 8'h05, 1'b0);
    loc_addr = 5'h05; loc_wdata = 8'h33;
    stb_q.push_back({5'h05, 8'h77});
    write_byte(8'h77, 1'b1, ack);
    check("coll_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    i2c_start();
    wr("collr_addr_ack", 8'h52, 1'b0);
    wr("collr_ptr_ack", 8'h05, 1'b0);
    i2c_start();
    wr("collr_raddr_ack", 8'h53, 1'b0);
    rd_q.push_back(8'h77);
    rd("coll_rd", 1'b1);
    i2c_stop();

    // Reset while the target is pulling SDA for a 0 data bit.
    loc_write(5'h00, 8'h5A);
    i2c_start();
    wr("rstm_addr_ack", 8'h52, 1'b0);
    wr("rstm_ptr_ack", 8'h00, 1'b0);
    i2c_start();
    wr("rstm_raddr_ack", 8'h53, 1'b0);
    repeat (2) @(negedge clk);
    check("rstm_drive0", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_release", {31'd0, sda_oe}, 32'd0);
    check("rstm_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    loc_write(5'h00, 8'hC3);
    i2c_start();
    wr("rstm_new_ack", 8'h53, 1'b0);
    rd_q.push_back(8'hC3);
    rd("rstm_rd_ptr0", 1'b1);
    i2c_stop();

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("stb_q_drained", stb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
